// File: rtl/ctrl_pkg.sv
// Shared types for the ID->EX control path: ALU ops, field encodings
// and the ctrl_t bundle carried from decode into the EX register.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_NOR  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_ADD  = 4'd4,
    ALU_SUB  = 4'd5,
    ALU_MULT = 4'd6,
    ALU_MULU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_SLT  = 4'd12,
    ALU_SLTU = 4'd13
  } alu_op_t;

  typedef enum logic [1:0] {
    RS_ALU  = 2'd0,
    RS_HI   = 2'd1,
    RS_LO   = 2'd2,
    RS_GPIO = 2'd3
  } regsel_t;

  typedef enum logic [1:0] {
    SRC_RD2  = 2'd0,
    SRC_SEXT = 2'd1,
    SRC_ZEXT = 2'd2
  } alu_src_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef struct packed {
    logic     valid;
    logic     illegal;
    alu_op_t  alu_op;
    logic [4:0] shamt;
    logic     enhilo;
    regsel_t  regsel;
    logic     regwrite;
    logic     rdrt;
    logic     memwrite;
    alu_src_t alu_src;
    logic     gpio_out;
    logic     gpio_in;
  } ctrl_t;

  // Instructions that touch HI/LO and must wait out a multiply
  function automatic logic uses_hilo(input logic [31:0] instr);
    logic [5:0] fn;
    fn = instr[5:0];
    return (instr[31:26] == OP_RTYPE) &&
           (fn == F_MFHI || fn == F_MFLO ||
            fn == F_MULT || fn == F_MULTU);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of one instruction word into EX-stage control.
// Unused fields are zero when ZERO_DC is set, X otherwise.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit GPIO_EN = 1'b1,
  parameter bit ZERO_DC = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] sh;
  logic       is_r;
  alu_op_t    dc_op;
  logic [4:0] dc_sh;

  assign op    = instr[31:26];
  assign fn    = instr[5:0];
  assign sh    = instr[10:6];
  assign is_r  = (op == OP_RTYPE);
  assign dc_op = ZERO_DC ? ALU_AND : alu_op_t'(4'bxxxx);
  assign dc_sh = ZERO_DC ? 5'd0 : 5'bxxxxx;

  always_comb begin
    ctrl        = '0;
    ctrl.valid  = 1'b1;
    ctrl.alu_op = dc_op;
    ctrl.shamt  = dc_sh;
    unique case (1'b1)
      is_r && (fn == F_ADD): begin
        ctrl.alu_op   = ALU_ADD;
        ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_SUB): begin
        ctrl.alu_op   = ALU_SUB;
        ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_AND): begin
        ctrl.alu_op   = ALU_AND;
        ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_OR): begin
        ctrl.alu_op   = ALU_OR;
        ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_NOR): begin
        ctrl.alu_op   = ALU_NOR;
        ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_XOR): begin
        ctrl.alu_op   = ALU_XOR;
        ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_SLT): begin
        ctrl.alu_op   = ALU_SLT;
        ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_SLTU): begin
        ctrl.alu_op   = ALU_SLTU;
        ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_MULT): begin
        ctrl.alu_op = ALU_MULT;
        ctrl.enhilo = 1'b1;
      end
      is_r && (fn == F_MULTU): begin
        ctrl.alu_op = ALU_MULU;
        ctrl.enhilo = 1'b1;
      end
      is_r && (fn == F_MFHI): begin
        ctrl.regsel   = RS_HI;
        ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_MFLO): begin
        ctrl.regsel   = RS_LO;
        ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_SLL): begin
        ctrl.alu_op   = ALU_SLL;
        ctrl.shamt    = sh;
        ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_SRL): begin
        ctrl.alu_op = ALU_SRL;
        ctrl.shamt  = sh;
        if (GPIO_EN && sh == 5'd0)
          ctrl.gpio_out = 1'b1;
        else
          ctrl.regwrite = 1'b1;
      end
      is_r && (fn == F_SRA): begin
        ctrl.alu_op   = ALU_SRA;
        ctrl.shamt    = sh;
        ctrl.regwrite = 1'b1;
        if (GPIO_EN && sh == 5'd0) begin
          ctrl.gpio_in = 1'b1;
          ctrl.regsel  = RS_GPIO;
        end
      end
      op == OP_LUI: begin
        ctrl.alu_op   = ALU_SLL;
        ctrl.shamt    = 5'd16;
        ctrl.alu_src  = SRC_ZEXT;
        ctrl.rdrt     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      (op == OP_ADDI) || (op == OP_ADDIU): begin
        ctrl.alu_op   = ALU_ADD;
        ctrl.alu_src  = SRC_SEXT;
        ctrl.rdrt     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      op == OP_SLTI: begin
        ctrl.alu_op   = ALU_SLT;
        ctrl.alu_src  = SRC_SEXT;
        ctrl.rdrt     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      op == OP_ANDI: begin
        ctrl.alu_op   = ALU_AND;
        ctrl.alu_src  = SRC_ZEXT;
        ctrl.rdrt     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      op == OP_ORI: begin
        ctrl.alu_op   = ALU_OR;
        ctrl.alu_src  = SRC_ZEXT;
        ctrl.rdrt     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      op == OP_XORI: begin
        ctrl.alu_op   = ALU_XOR;
        ctrl.alu_src  = SRC_ZEXT;
        ctrl.rdrt     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // The all-zero word is sll $0,$0,0: keep it valid but harmless
    if (instr == 32'h0)
      ctrl.regwrite = 1'b0;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID->EX control register with HI/LO busy interlock,
// stall/flush bubbles and illegal-instruction flagging.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter bit GPIO_EN  = 1'b1,
  parameter bit ZERO_DC  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_ID,
  input  logic        valid_ID,
  input  logic        stall_EX,
  input  logic        flush,
  output logic        stall_ID,
  output logic        valid_EX,
  output logic [3:0]  alu_op_EX,
  output logic [4:0]  shamt_EX,
  output logic        enhilo_EX,
  output logic [1:0]  regsel_EX,
  output logic        regwrite_EX,
  output logic        rdrt_EX,
  output logic        memwrite_EX,
  output logic [1:0]  alu_src_EX,
  output logic        gpio_out_EX,
  output logic        gpio_in_EX,
  output logic        illegal_EX,
  output logic        hilo_busy
);

  localparam int CW = $clog2(MULT_LAT + 1);

  ctrl_t         dec;
  ctrl_t         ex;
  logic [CW-1:0] cnt;
  logic          take;

  ctrl_decode #(
    .GPIO_EN (GPIO_EN),
    .ZERO_DC (ZERO_DC)
  ) u_dec (
    .instr (instr_ID),
    .ctrl  (dec)
  );

  assign hilo_busy = (cnt != '0);
  assign stall_ID  = valid_ID & hilo_busy & uses_hilo(instr_ID);
  assign take      = valid_ID & ~flush & ~stall_ID;

  // Counter keeps running under stall_EX; only a real load restarts it
  always_ff @(posedge clk) begin
    if (rst) begin
      ex  <= '0;
      cnt <= '0;
    end else begin
      if (!stall_EX && take && dec.enhilo)
        cnt <= CW'(MULT_LAT);
      else if (hilo_busy)
        cnt <= cnt - CW'(1);
      if (!stall_EX)
        ex <= take ? dec : '0;
    end
  end

  assign valid_EX    = ex.valid;
  assign alu_op_EX   = ex.alu_op;
  assign shamt_EX    = ex.shamt;
  assign enhilo_EX   = ex.enhilo;
  assign regsel_EX   = ex.regsel;
  assign regwrite_EX = ex.regwrite;
  assign rdrt_EX     = ex.rdrt;
  assign memwrite_EX = ex.memwrite;
  assign alu_src_EX  = ex.alu_src;
  assign gpio_out_EX = ex.gpio_out;
  assign gpio_in_EX  = ex.gpio_in;
  assign illegal_EX  = ex.illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: expected EX words are queued
// when an instruction is driven and compared one cycle later.
module tb_pipe_ctrl_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr_ID;
  logic        valid_ID;
  logic        stall_EX;
  logic        flush;

  logic        stall_ID, valid_EX, enhilo_EX, regwrite_EX, rdrt_EX;
  logic        memwrite_EX, gpio_out_EX, gpio_in_EX, illegal_EX;
  logic        hilo_busy;
  logic [3:0]  alu_op_EX;
  logic [4:0]  shamt_EX;
  logic [1:0]  regsel_EX, alu_src_EX;

  logic        g_stall_ID, g_valid_EX, g_enhilo_EX, g_regwrite_EX, g_rdrt_EX;
  logic        g_memwrite_EX, g_gpio_out_EX, g_gpio_in_EX, g_illegal_EX;
  logic        g_hilo_busy;
  logic [3:0]  g_alu_op_EX;
  logic [4:0]  g_shamt_EX;
  logic [1:0]  g_regsel_EX, g_alu_src_EX;

  int n_cmp;
  int n_bad;
  logic [20:0] sb[$];

  pipe_ctrl_unit #(.MULT_LAT(4), .GPIO_EN(1'b1), .ZERO_DC(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_ID(instr_ID), .valid_ID(valid_ID),
    .stall_EX(stall_EX), .flush(flush), .stall_ID(stall_ID),
    .valid_EX(valid_EX), .alu_op_EX(alu_op_EX), .shamt_EX(shamt_EX),
    .enhilo_EX(enhilo_EX), .regsel_EX(regsel_EX),
    .regwrite_EX(regwrite_EX), .rdrt_EX(rdrt_EX),
    .memwrite_EX(memwrite_EX), .alu_src_EX(alu_src_EX),
    .gpio_out_EX(gpio_out_EX), .gpio_in_EX(gpio_in_EX),
    .illegal_EX(illegal_EX), .hilo_busy(hilo_busy)
  );

  pipe_ctrl_unit #(.MULT_LAT(4), .GPIO_EN(1'b0), .ZERO_DC(1'b1)) dut_ng (
    .clk(clk), .rst(rst), .instr_ID(instr_ID), .valid_ID(valid_ID),
    .stall_EX(stall_EX), .flush(flush), .stall_ID(g_stall_ID),
    .valid_EX(g_valid_EX), .alu_op_EX(g_alu_op_EX),
    .shamt_EX(g_shamt_EX), .enhilo_EX(g_enhilo_EX),
    .regsel_EX(g_regsel_EX), .regwrite_EX(g_regwrite_EX),
    .rdrt_EX(g_rdrt_EX), .memwrite_EX(g_memwrite_EX),
    .alu_src_EX(g_alu_src_EX), .gpio_out_EX(g_gpio_out_EX),
    .gpio_in_EX(g_gpio_in_EX), .illegal_EX(g_illegal_EX),
    .hilo_busy(g_hilo_busy)
  );

  logic [20:0] ex_vec;
  logic [20:0] ng_vec;
  assign ex_vec = {valid_EX, illegal_EX, alu_op_EX, shamt_EX, enhilo_EX,
                   regsel_EX, regwrite_EX, rdrt_EX, memwrite_EX,
                   alu_src_EX, gpio_out_EX, gpio_in_EX};
  assign ng_vec = {g_valid_EX, g_illegal_EX, g_alu_op_EX, g_shamt_EX,
                   g_enhilo_EX, g_regsel_EX, g_regwrite_EX, g_rdrt_EX,
                   g_memwrite_EX, g_alu_src_EX, g_gpio_out_EX,
                   g_gpio_in_EX};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // memwrite is always expected 0
  function automatic logic [20:0] ev(
    input logic v, input logic ill, input logic [3:0] op,
    input logic [4:0] sh, input logic hl, input logic [1:0] rs,
    input logic rw, input logic rdrt, input logic [1:0] src,
    input logic go, input logic gi);
    return {v, ill, op, sh, hl, rs, rw, rdrt, 1'b0, src, go, gi};
  endfunction

  localparam logic [20:0] BUB = 21'd0;

  task automatic cyc(input string tag, input logic [31:0] ins,
                     input logic v, input logic fl, input logic sx,
                     input logic est, input logic ebusy,
                     input logic [20:0] eex);
    instr_ID = ins;
    valid_ID = v;
    flush    = fl;
    stall_EX = sx;
    #1;
    check_eq({tag, "_stall"}, 32'(stall_ID), 32'(est));
    sb.push_back(eex);
    @(negedge clk);
    check_eq({tag, "_busy"}, 32'(hilo_busy), 32'(ebusy));
    if (sb.size() == 0)
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    else
      check_eq(tag, 32'(ex_vec), 32'(sb.pop_front()));
  endtask

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_SUB  = 32'h00221822;
  localparam logic [31:0] I_SLL5 = 32'h00011940;
  localparam logic [31:0] I_SRA3 = 32'h000118C3;
  localparam logic [31:0] I_MULT = 32'h00220018;
  localparam logic [31:0] I_MFLO = 32'h00001812;
  localparam logic [31:0] I_MFHI = 32'h00001810;
  localparam logic [31:0] I_SRL0 = 32'h00011802;
  localparam logic [31:0] I_SRA0 = 32'h00011803;
  localparam logic [31:0] I_LUI  = 32'h3C011234;
  localparam logic [31:0] I_ADDI = 32'h20220005;
  localparam logic [31:0] I_ORI  = 32'h34220005;
  localparam logic [31:0] I_SLTI = 32'h28220005;
  localparam logic [31:0] I_BAD  = 32'hFC000000;
  localparam logic [31:0] I_ADDU = 32'h00221821;

  logic [20:0] e_add, e_mult;

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    instr_ID = 32'h0;
    valid_ID = 1'b0;
    stall_EX = 1'b0;
    flush    = 1'b0;
    e_add  = ev(1, 0, 4'd4, 5'd0, 0, 2'd0, 1, 0, 2'd0, 0, 0);
    e_mult = ev(1, 0, 4'd6, 5'd0, 1, 2'd0, 0, 0, 2'd0, 0, 0);

    repeat (2) @(negedge clk);
    check_eq("rst_ex", 32'(ex_vec), 32'd0);
    check_eq("rst_busy", 32'(hilo_busy), 32'd0);
    rst = 1'b0;

    cyc("add", I_ADD, 1, 0, 0, 0, 0, e_add);
    cyc("sub", I_SUB, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd5, 5'd0, 0, 2'd0, 1, 0, 2'd0, 0, 0));
    cyc("sll5", I_SLL5, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd8, 5'd5, 0, 2'd0, 1, 0, 2'd0, 0, 0));
    cyc("sra3", I_SRA3, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd10, 5'd3, 0, 2'd0, 1, 0, 2'd0, 0, 0));

    // mult then mflo: four stalled cycles, then mflo issues
    cyc("mult", I_MULT, 1, 0, 0, 0, 1, e_mult);
    cyc("mflo_s1", I_MFLO, 1, 0, 0, 1, 1, BUB);
    cyc("mflo_s2", I_MFLO, 1, 0, 0, 1, 1, BUB);
    cyc("mflo_s3", I_MFLO, 1, 0, 0, 1, 1, BUB);
    cyc("mflo_s4", I_MFLO, 1, 0, 0, 1, 0, BUB);
    cyc("mflo", I_MFLO, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd0, 5'd0, 0, 2'd2, 1, 0, 2'd0, 0, 0));

    cyc("gpio_out", I_SRL0, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd9, 5'd0, 0, 2'd0, 0, 0, 2'd0, 1, 0));
    check_eq("ng_srl0", 32'(ng_vec),
             32'(ev(1, 0, 4'd9, 5'd0, 0, 2'd0, 1, 0, 2'd0, 0, 0)));
    cyc("gpio_in", I_SRA0, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd10, 5'd0, 0, 2'd3, 1, 0, 2'd0, 0, 1));
    check_eq("ng_sra0", 32'(ng_vec),
             32'(ev(1, 0, 4'd10, 5'd0, 0, 2'd0, 1, 0, 2'd0, 0, 0)));
    cyc("mfhi", I_MFHI, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd0, 5'd0, 0, 2'd1, 1, 0, 2'd0, 0, 0));

    cyc("flush_mult", I_MULT, 1, 1, 0, 0, 0, BUB);
    cyc("add2", I_ADD, 1, 0, 0, 0, 0, e_add);
    cyc("sx_flush", I_SUB, 1, 1, 1, 0, 0, e_add);
    cyc("sx_hold", I_SUB, 1, 0, 1, 0, 0, e_add);

    // busy counter keeps draining while EX is held
    cyc("mult2", I_MULT, 1, 0, 0, 0, 1, e_mult);
    cyc("sx_mult", 32'h0, 0, 0, 1, 0, 1, e_mult);
    cyc("drain1", I_MFHI, 0, 0, 0, 0, 1, BUB);
    cyc("drain2", 32'h0, 0, 0, 0, 0, 1, BUB);
    cyc("drain3", 32'h0, 0, 0, 0, 0, 0, BUB);

    cyc("lui", I_LUI, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd8, 5'd16, 0, 2'd0, 1, 1, 2'd2, 0, 0));
    cyc("addi", I_ADDI, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd4, 5'd0, 0, 2'd0, 1, 1, 2'd1, 0, 0));
    cyc("ori", I_ORI, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd1, 5'd0, 0, 2'd0, 1, 1, 2'd2, 0, 0));
    cyc("slti", I_SLTI, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd12, 5'd0, 0, 2'd0, 1, 1, 2'd1, 0, 0));
    cyc("ill_op", I_BAD, 1, 0, 0, 0, 0,
        ev(1, 1, 4'd0, 5'd0, 0, 2'd0, 0, 0, 2'd0, 0, 0));
    cyc("ill_fn", I_ADDU, 1, 0, 0, 0, 0,
        ev(1, 1, 4'd0, 5'd0, 0, 2'd0, 0, 0, 2'd0, 0, 0));
    cyc("nop", 32'h0, 1, 0, 0, 0, 0,
        ev(1, 0, 4'd8, 5'd0, 0, 2'd0, 0, 0, 2'd0, 0, 0));
    cyc("invalid", I_ADD, 0, 0, 0, 0, 0, BUB);

    // reset while the counter sits at 2
    cyc("mult3", I_MULT, 1, 0, 0, 0, 1, e_mult);
    cyc("idle1", 32'h0, 0, 0, 0, 0, 1, BUB);
    cyc("idle2", 32'h0, 0, 0, 0, 0, 1, BUB);
    rst      = 1'b1;
    instr_ID = I_MFLO;
    valid_ID = 1'b1;
    #1;
    check_eq("cnt2_stall", 32'(stall_ID), 32'd1);
    @(negedge clk);
    check_eq("rst2_busy", 32'(hilo_busy), 32'd0);
    check_eq("rst2_ex", 32'(ex_vec), 32'd0);
    rst = 1'b0;
    valid_ID = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
